// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, grant choice and the latched request.
// The latched-request struct is sized by MEM_ADDR_W/MEM_DATA_W, which the top uses as its defaults.
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_BE_W   = MEM_DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT_INS,
        S_GRANT_DATA,
        S_DONE_INS,
        S_DONE_DATA
    } arb_state_t;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_INS,
        GRANT_DATA
    } arb_grant_t;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        logic [MEM_BE_W-1:0]   be;
    } mem_txn_t;

    // Data is favoured unless fetch has been starved past the limit.
    function automatic arb_grant_t pick_grant(input logic data_req,
                                              input logic ins_req,
                                              input logic starved);
        if (ins_req && starved) return GRANT_INS;
        if (data_req)           return GRANT_DATA;
        if (ins_req)            return GRANT_INS;
        return GRANT_NONE;
    endfunction

endpackage

// File: rtl/mem_arb_starve_counter.sv
// Counts data grants taken while fetch is waiting; flags starvation at STARVE_LIMIT.
// Saturates at the limit and clears whenever fetch is granted.
module mem_arb_starve_counter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic data_grant,
    input  logic ins_grant,
    input  logic ins_req,
    output logic starved
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (ins_grant) begin
            count <= '0;
        end else if (data_grant && ins_req && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign starved = (count == LIMIT);

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one single-ported memory between the fetch port and the data port, one transaction in flight.
// Define MEM_ARB_FAIRNESS_EN to grant fetch after STARVE_LIMIT consecutive data grants made while it waited.
module memory_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = MEM_ADDR_W,
    parameter int DATA_W       = MEM_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ins_req,
    input  logic [ADDR_W-1:0]   ins_addr,
    output logic [DATA_W-1:0]   ins_rdata,
    output logic                ins_busy,
    input  logic                data_req,
    input  logic                data_we,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    input  logic [DATA_W/8-1:0] data_be,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_busy,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready
);

    arb_state_t state;
    arb_grant_t grant;
    mem_txn_t   txn;
    logic       starved;

`ifdef MEM_ARB_FAIRNESS_EN
    mem_arb_starve_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_counter (
        .clk        (clk),
        .reset      (reset),
        .data_grant ((state == S_IDLE) && (grant == GRANT_DATA)),
        .ins_grant  ((state == S_IDLE) && (grant == GRANT_INS)),
        .ins_req    (ins_req),
        .starved    (starved)
    );
`else
    // Strict data priority: STARVE_LIMIT has no effect in this build.
    assign starved = 1'b0;
`endif

    assign grant = pick_grant(data_req, ins_req, starved);

    // NOTE: every register here, including the latched request and read data, is async-reset so an
    // aborted transaction leaves no stale address or data on the memory bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            txn        <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            ins_rdata  <= '0;
            data_rdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    case (grant)
                        GRANT_DATA: begin
                            txn     <= '{we: data_we, addr: data_addr, wdata: data_wdata, be: data_be};
                            mem_req <= 1'b1;
                            mem_we  <= data_we;
                            state   <= S_GRANT_DATA;
                        end
                        GRANT_INS: begin
                            txn     <= '{we: 1'b0, addr: ins_addr, wdata: '0, be: '1};
                            mem_req <= 1'b1;
                            mem_we  <= 1'b0;
                            state   <= S_GRANT_INS;
                        end
                        default: state <= S_IDLE;
                    endcase
                end
                S_GRANT_INS: begin
                    if (mem_ready) begin
                        ins_rdata <= mem_rdata;
                        mem_req   <= 1'b0;
                        state     <= S_DONE_INS;
                    end
                end
                S_GRANT_DATA: begin
                    if (mem_ready) begin
                        if (!txn.we) begin
                            data_rdata <= mem_rdata;
                        end
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= S_DONE_DATA;
                    end
                end
                S_DONE_INS, S_DONE_DATA: state <= S_IDLE;
                default:                 state <= S_IDLE;
            endcase
        end
    end

    assign mem_addr  = txn.addr;
    assign mem_wdata = txn.wdata;
    assign mem_be    = txn.be;

    // Busy drops only for the single DONE cycle of the requester's own transaction.
    assign ins_busy  = ins_req  && (state != S_DONE_INS);
    assign data_busy = data_req && (state != S_DONE_DATA);

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: a table of single transactions plus hand-written
// sequences for collision, starvation, reset abort and a spurious mem_ready.
module tb_memory_port_arbiter;

    logic        clk;
    logic        reset;
    logic        ins_req;
    logic [31:0] ins_addr;
    logic [31:0] ins_rdata;
    logic        ins_busy;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_be;
    logic [31:0] data_rdata;
    logic        data_busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    memory_port_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ins_req    (ins_req),
        .ins_addr   (ins_addr),
        .ins_rdata  (ins_rdata),
        .ins_busy   (ins_busy),
        .data_req   (data_req),
        .data_we    (data_we),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_be    (data_be),
        .data_rdata (data_rdata),
        .data_busy  (data_busy),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_data;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        int          delay;
        logic [31:0] exp_ins;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[5];
    vec_t post_reset_vec;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_grant(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_grant_seen"}, 64'(ok), 64'd1);
    endtask

    // Called at a negedge inside a grant cycle; returns #1 after the edge that enters DONE.
    task automatic pulse_ready(input int delay, input logic [31:0] rd);
        if (delay > 0) begin
            repeat (delay) @(posedge clk);
            #1;
        end
        mem_ready = 1'b1;
        mem_rdata = rd;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        bit ok;
        @(posedge clk);
        #1;
        if (v.is_data) begin
            data_req   = 1'b1;
            data_we    = v.we;
            data_addr  = v.addr;
            data_wdata = v.wdata;
            data_be    = v.be;
        end else begin
            ins_req  = 1'b1;
            ins_addr = v.addr;
        end
        wait_grant($sformatf("v%0d", idx), ok);
        if (ok) begin
            check($sformatf("v%0d_mem_we", idx), 64'(mem_we), 64'(v.is_data ? v.we : 1'b0));
            check($sformatf("v%0d_mem_addr", idx), 64'(mem_addr), 64'(v.addr));
            check($sformatf("v%0d_mem_be", idx), 64'(mem_be), 64'(v.is_data ? v.be : 4'hf));
            if (v.is_data && v.we)
                check($sformatf("v%0d_mem_wdata", idx), 64'(mem_wdata), 64'(v.wdata));
            check($sformatf("v%0d_busy_in_grant", idx),
                  64'(v.is_data ? data_busy : ins_busy), 64'd1);
            pulse_ready(v.delay, v.rdata);
            @(negedge clk);
            check($sformatf("v%0d_busy_in_done", idx),
                  64'(v.is_data ? data_busy : ins_busy), 64'd0);
            check($sformatf("v%0d_mem_req_in_done", idx), 64'(mem_req), 64'd0);
        end
        @(posedge clk);
        #1;
        ins_req  = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_ins_rdata", idx), 64'(ins_rdata), 64'(v.exp_ins));
        check($sformatf("v%0d_data_rdata", idx), 64'(data_rdata), 64'(v.exp_data));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        bit is_ins;
        bit ins_served;

        //           data we  addr          wdata         be     mem_rdata     dly exp_ins       exp_data
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,        4'h0,  32'h2408_0005, 2, 32'h2408_0005, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'h3, 32'h1111_1111, 1, 32'h2408_0005, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0204, 32'h0,        4'hf,  32'hCAFE_F00D, 0, 32'h2408_0005, 32'hCAFE_F00D};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,        4'h0,  32'h0000_0013, 3, 32'h0000_0013, 32'hCAFE_F00D};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_0208, 32'h1234_5678, 4'hc, 32'h2222_2222, 0, 32'h0000_0013, 32'hCAFE_F00D};
        post_reset_vec = '{1'b0, 1'b0, 32'h0000_0800, 32'h0, 4'h0, 32'hBEEF_0001, 1, 32'hBEEF_0001, 32'h0};

        reset      = 1'b1;
        ins_req    = 1'b0;
        ins_addr   = '0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_addr  = '0;
        data_wdata = '0;
        data_be    = '0;
        mem_rdata  = '0;
        mem_ready  = 1'b0;
        #1;
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_mem_be", 64'(mem_be), 64'd0);
        check("rst_ins_rdata", 64'(ins_rdata), 64'd0);
        check("rst_data_rdata", 64'(data_rdata), 64'd0);
        check("rst_busy", 64'({ins_busy, data_busy}), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Collision: data wins, fetch follows after data's DONE/IDLE.
        @(posedge clk);
        #1;
        ins_req   = 1'b1;
        ins_addr  = 32'h0000_0300;
        data_req  = 1'b1;
        data_we   = 1'b0;
        data_addr = 32'h0000_0400;
        data_be   = 4'hf;
        wait_grant("coll_data", ok);
        check("coll_first_addr", 64'(mem_addr), 64'h400);
        check("coll_ins_waits", 64'(ins_busy), 64'd1);
        pulse_ready(1, 32'hA5A5_A5A5);
        @(negedge clk);
        check("coll_data_done_busy", 64'({ins_busy, data_busy}), 64'b10);
        @(posedge clk);
        #1;
        data_req = 1'b0;
        wait_grant("coll_ins", ok);
        check("coll_second_addr", 64'(mem_addr), 64'h300);
        check("coll_second_be", 64'(mem_be), 64'hf);
        pulse_ready(0, 32'h5A5A_5A5A);
        @(negedge clk);
        check("coll_ins_done_busy", 64'(ins_busy), 64'd0);
        @(posedge clk);
        #1;
        ins_req = 1'b0;
        @(negedge clk);
        check("coll_data_rdata", 64'(data_rdata), 64'hA5A5_A5A5);
        check("coll_ins_rdata", 64'(ins_rdata), 64'h5A5A_5A5A);

        // Starvation: data write held continuously alongside a waiting fetch.
        @(posedge clk);
        #1;
        ins_req    = 1'b1;
        ins_addr   = 32'h0000_0600;
        data_req   = 1'b1;
        data_we    = 1'b1;
        data_addr  = 32'h0000_0500;
        data_wdata = 32'h0000_0001;
        data_be    = 4'hf;
        ins_served = 1'b0;
        for (int g = 0; g < 5; g++) begin
            wait_grant($sformatf("fair%0d", g), ok);
            is_ins = (mem_addr == 32'h0000_0600);
`ifdef MEM_ARB_FAIRNESS_EN
            check($sformatf("fair_grant%0d_is_ins", g), 64'(is_ins), 64'(g == 4));
`else
            check($sformatf("fair_grant%0d_is_ins", g), 64'(is_ins), 64'd0);
`endif
            pulse_ready(0, is_ins ? 32'h0000_0077 : 32'h0);
            if (is_ins) begin
                ins_served = 1'b1;
                @(negedge clk);
                check("fair_ins_done_busy", 64'(ins_busy), 64'd0);
                @(posedge clk);
                #1;
                ins_req = 1'b0;
            end
        end
        data_req = 1'b0;
        if (!ins_served) begin
            wait_grant("fair_release", ok);
            check("fair_release_addr", 64'(mem_addr), 64'h600);
            pulse_ready(0, 32'h0000_0077);
            @(posedge clk);
            #1;
            ins_req = 1'b0;
        end
        @(negedge clk);
        check("fair_ins_rdata", 64'(ins_rdata), 64'h77);
        check("fair_data_rdata", 64'(data_rdata), 64'hA5A5_A5A5);

        // Reset while a data read is in GRANT_DATA.
        @(posedge clk);
        #1;
        data_req  = 1'b1;
        data_we   = 1'b0;
        data_addr = 32'h0000_0700;
        wait_grant("abort", ok);
        reset = 1'b1;
        #1;
        check("abort_mem_req", 64'(mem_req), 64'd0);
        check("abort_mem_addr", 64'(mem_addr), 64'd0);
        check("abort_ins_rdata", 64'(ins_rdata), 64'd0);
        check("abort_data_rdata", 64'(data_rdata), 64'd0);
        data_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_idle_after_release", 64'(mem_req), 64'd0);
        run_vec(post_reset_vec, 5);

        // Spurious mem_ready in IDLE.
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        mem_rdata = '0;
        @(negedge clk);
        check("spur_mem_req", 64'(mem_req), 64'd0);
        check("spur_ins_rdata", 64'(ins_rdata), 64'hBEEF_0001);
        check("spur_data_rdata", 64'(data_rdata), 64'd0);
        check("spur_busy", 64'({ins_busy, data_busy}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
